vga_demo_top: RTL and testbench

- Top-level VGA demo for the simulated DE1 board; 160x120 pixel framebuffer, 3-bit colour.
- After reset it clears the screen to black, then animates a BOX x BOX square that bounces off the screen edges.
- Emits one pixel write per cycle on VGA_X/VGA_Y/VGA_COLOR/plot to the external framebuffer adapter.

---
 rtl/vga_demo_pkg.sv | 27 ++
 rtl/vga_demo_if.sv | 19 +
 rtl/vga_demo_rect_plotter.sv | 70 +++++++
 rtl/vga_demo_top.sv | 228 ++++++++++++++++++++++
 tb/tb_vga_demo_top.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_demo_pkg.sv
// Shared definitions for the VGA bouncing-box demo.
// Contents: screen geometry, coordinate widths, colour constants, FSM state
// codes, and the colour-advance helper.
package vga_demo_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;

  localparam logic [2:0] COLOR_BLACK = 3'b000;
  localparam logic [2:0] COLOR_WHITE = 3'b111;

  // FSM state codes, kept as plain constants so they are easy to bind to.
  typedef logic [2:0] state_t;
  localparam state_t ST_CLEAR = 3'd0;
  localparam state_t ST_DRAW  = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_ERASE = 3'd3;
  localparam state_t ST_MOVE  = 3'd4;

  // Colour cycles 1..7 and wraps back to 1. Black is reserved for erasing.
  function automatic logic [2:0] next_colour(input logic [2:0] c);
    return (c == 3'd7) ? 3'd1 : c + 3'd1;
  endfunction

endpackage

// File: rtl/vga_demo_if.sv
// Pixel-write bus from the demo to the external framebuffer adapter.
// Signals: VGA_X (0..159), VGA_Y (0..119), VGA_COLOR {R,G,B}, plot strobe,
// dbg_state (current FSM state, for observation only).
// Handshake: plot is a one-cycle valid strobe with no ready; the consumer
// must accept the pixel on every cycle plot is high. X/Y/COLOR are
// meaningful only while plot is high.
interface vga_demo_if;
  import vga_demo_pkg::*;

  logic [X_W-1:0] VGA_X;
  logic [Y_W-1:0] VGA_Y;
  logic [2:0]     VGA_COLOR;
  logic           plot;
  state_t         dbg_state;

  modport master (output VGA_X, VGA_Y, VGA_COLOR, plot, dbg_state);
  modport slave  (input  VGA_X, VGA_Y, VGA_COLOR, plot, dbg_state);

endinterface

// File: rtl/vga_demo_rect_plotter.sv
// rect_plotter: emits one pixel per cycle covering a rectangle in raster
// order (x fastest). Geometry and colour are latched on i_start while idle;
// starts while busy are ignored. Width and height must be at least 1.
// Ports: clk, rst (sync, active high), i_start, i_x0, i_y0, i_width,
// i_height, i_colour; o_x, o_y, o_colour, o_plot (pixel valid),
// o_done (high together with the last pixel).
module rect_plotter
  import vga_demo_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [X_W-1:0] i_x0,
  input  logic [Y_W-1:0] i_y0,
  input  logic [X_W-1:0] i_width,
  input  logic [Y_W-1:0] i_height,
  input  logic [2:0]     i_colour,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic [2:0]     o_colour,
  output logic           o_plot,
  output logic           o_done
);

  logic           r_busy;
  logic [X_W-1:0] r_x0, r_w, r_cx;
  logic [Y_W-1:0] r_y0, r_h, r_cy;
  logic [2:0]     r_col;

  logic w_last_col, w_last_row;
  assign w_last_col = (r_cx == r_w - X_W'(1));
  assign w_last_row = (r_cy == r_h - Y_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_x0   <= '0;
      r_y0   <= '0;
      r_w    <= '0;
      r_h    <= '0;
      r_cx   <= '0;
      r_cy   <= '0;
      r_col  <= COLOR_BLACK;
    end else if (!r_busy) begin
      if (i_start) begin
        r_busy <= 1'b1;
        r_x0   <= i_x0;
        r_y0   <= i_y0;
        r_w    <= i_width;
        r_h    <= i_height;
        r_col  <= i_colour;
        r_cx   <= '0;
        r_cy   <= '0;
      end
    end else if (w_last_col) begin
      r_cx <= '0;
      if (w_last_row) r_busy <= 1'b0;
      else            r_cy   <= r_cy + Y_W'(1);
    end else begin
      r_cx <= r_cx + X_W'(1);
    end
  end

  assign o_x      = r_x0 + r_cx;
  assign o_y      = r_y0 + r_cy;
  assign o_colour = r_col;
  assign o_plot   = r_busy;
  assign o_done   = r_busy && w_last_col && w_last_row;

endmodule

// File: rtl/vga_demo_top.sv
// vga_demo_top: clears a 160x120 framebuffer to black after reset, then
// animates a BOX x BOX square bouncing off the screen edges, one pixel
// write per cycle. All pixel outputs are registered (one cycle behind the
// plotter).
// Ports: CLOCK_50 (clock), KEY[0] sync active-high reset, KEY[1] colour
// advance on rising edge (synchronised), KEY[2] pause while high, KEY[3]
// unused; vga (vga_demo_if master): VGA_X, VGA_Y, VGA_COLOR, plot, dbg_state.
// Build option: define VGA_DEMO_TRAIL_EN to skip the erase pass, leaving a
// trail of previous boxes on screen.
module vga_demo_top
  import vga_demo_pkg::*;
#(
  parameter int TICK_CYCLES = 833333,
  parameter int BOX         = 8
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  vga_demo_if.master vga
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [X_W-1:0] X_LIMIT   = X_W'(SCREEN_W - BOX);
  localparam logic [Y_W-1:0] Y_LIMIT   = Y_W'(SCREEN_H - BOX);
  localparam logic [X_W-1:0] BOX_W     = X_W'(BOX);
  localparam logic [Y_W-1:0] BOX_H     = Y_W'(BOX);
  localparam logic [X_W-1:0] FULL_W    = X_W'(SCREEN_W);
  localparam logic [Y_W-1:0] FULL_H    = Y_W'(SCREEN_H);

  logic w_rst;
  logic w_pause;
  logic w_unused_key3;
  assign w_rst         = KEY[0];
  assign w_pause       = KEY[2];
  assign w_unused_key3 = KEY[3];

  // Animation tick: free-running, counts in every state.
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (w_rst)       r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  // KEY[1]: two-flop synchroniser plus edge detector; the plotter latches
  // the colour at the start of each draw, so a change never splits a box.
  logic       r_key1_meta, r_key1_sync, r_key1_prev;
  logic [2:0] r_colour;

  always_ff @(posedge CLOCK_50) begin
    if (w_rst) begin
      r_key1_meta <= 1'b0;
      r_key1_sync <= 1'b0;
      r_key1_prev <= 1'b0;
      r_colour    <= COLOR_WHITE;
    end else begin
      r_key1_meta <= KEY[1];
      r_key1_sync <= r_key1_meta;
      r_key1_prev <= r_key1_sync;
      if (r_key1_sync && !r_key1_prev) r_colour <= next_colour(r_colour);
    end
  end

  // Box position and direction (r_*_neg set means moving toward 0).
  state_t         r_state;
  logic           r_start;
  logic [X_W-1:0] r_x0;
  logic [Y_W-1:0] r_y0;
  logic           r_dx_neg, r_dy_neg;

  // Bounce: if the step would leave the legal range, flip direction first
  // and then step by the flipped direction.
  logic [X_W-1:0] w_nx;
  logic [Y_W-1:0] w_ny;
  logic           w_ndx_neg, w_ndy_neg;

  always_comb begin
    w_nx      = r_x0;
    w_ndx_neg = r_dx_neg;
    if (!r_dx_neg) begin
      if (r_x0 >= X_LIMIT) begin
        w_ndx_neg = 1'b1;
        w_nx      = r_x0 - X_W'(1);
      end else begin
        w_nx      = r_x0 + X_W'(1);
      end
    end else begin
      if (r_x0 == '0) begin
        w_ndx_neg = 1'b0;
        w_nx      = r_x0 + X_W'(1);
      end else begin
        w_nx      = r_x0 - X_W'(1);
      end
    end
  end

  always_comb begin
    w_ny      = r_y0;
    w_ndy_neg = r_dy_neg;
    if (!r_dy_neg) begin
      if (r_y0 >= Y_LIMIT) begin
        w_ndy_neg = 1'b1;
        w_ny      = r_y0 - Y_W'(1);
      end else begin
        w_ny      = r_y0 + Y_W'(1);
      end
    end else begin
      if (r_y0 == '0) begin
        w_ndy_neg = 1'b0;
        w_ny      = r_y0 + Y_W'(1);
      end else begin
        w_ny      = r_y0 - Y_W'(1);
      end
    end
  end

  // Plotter request: r_start is raised on the same edge that enters a
  // drawing state, so these selections already reflect the new state
  // (and the freshly moved position) when the plotter latches them.
  logic [X_W-1:0] w_px0, w_pw, w_px;
  logic [Y_W-1:0] w_py0, w_ph, w_py;
  logic [2:0]     w_pcol, w_pcol_out;
  logic           w_pplot, w_pdone;

  always_comb begin
    w_px0  = r_x0;
    w_py0  = r_y0;
    w_pw   = BOX_W;
    w_ph   = BOX_H;
    w_pcol = r_colour;
    if (r_state == ST_CLEAR) begin
      w_px0  = '0;
      w_py0  = '0;
      w_pw   = FULL_W;
      w_ph   = FULL_H;
      w_pcol = COLOR_BLACK;
    end else if (r_state == ST_ERASE) begin
      w_pcol = COLOR_BLACK;
    end
  end

  rect_plotter u_plotter (
    .clk      (CLOCK_50),
    .rst      (w_rst),
    .i_start  (r_start),
    .i_x0     (w_px0),
    .i_y0     (w_py0),
    .i_width  (w_pw),
    .i_height (w_ph),
    .i_colour (w_pcol),
    .o_x      (w_px),
    .o_y      (w_py),
    .o_colour (w_pcol_out),
    .o_plot   (w_pplot),
    .o_done   (w_pdone)
  );

  always_ff @(posedge CLOCK_50) begin
    if (w_rst) begin
      r_state  <= ST_CLEAR;
      r_start  <= 1'b1;
      r_x0     <= '0;
      r_y0     <= '0;
      r_dx_neg <= 1'b0;
      r_dy_neg <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_CLEAR: if (w_pdone) begin
          r_state <= ST_DRAW;
          r_start <= 1'b1;
        end
        ST_DRAW: if (w_pdone) r_state <= ST_WAIT;
        ST_WAIT: if (w_tick && !w_pause) begin
`ifdef VGA_DEMO_TRAIL_EN
          r_state <= ST_MOVE;
`else
          r_state <= ST_ERASE;
          r_start <= 1'b1;
`endif
        end
        ST_ERASE: if (w_pdone) r_state <= ST_MOVE;
        ST_MOVE: begin
          r_x0     <= w_nx;
          r_y0     <= w_ny;
          r_dx_neg <= w_ndx_neg;
          r_dy_neg <= w_ndy_neg;
          r_state  <= ST_DRAW;
          r_start  <= 1'b1;
        end
        default: begin
          r_state <= ST_CLEAR;
          r_start <= 1'b1;
        end
      endcase
    end
  end

  // Registered pixel outputs.
  logic [X_W-1:0] r_vga_x;
  logic [Y_W-1:0] r_vga_y;
  logic [2:0]     r_vga_color;
  logic           r_plot;

  always_ff @(posedge CLOCK_50) begin
    if (w_rst) begin
      r_vga_x     <= '0;
      r_vga_y     <= '0;
      r_vga_color <= COLOR_BLACK;
      r_plot      <= 1'b0;
    end else begin
      r_vga_x     <= w_px;
      r_vga_y     <= w_py;
      r_vga_color <= w_pcol_out;
      r_plot      <= w_pplot;
    end
  end

  assign vga.VGA_X     = r_vga_x;
  assign vga.VGA_Y     = r_vga_y;
  assign vga.VGA_COLOR = r_vga_color;
  assign vga.plot      = r_plot;
  assign vga.dbg_state = r_state;

endmodule

// File: tb/tb_vga_demo_top.sv
// Testbench for vga_demo_top: a behavioural model turns each animation
// step into the list of pixel writes it must produce, and a scoreboard
// compares every plot pulse against that list in order.
module tb_vga_demo_top;
  import vga_demo_pkg::*;

  localparam int TICK = 64;
  localparam int BOX  = 8;
  localparam int SW   = 160;
  localparam int SH   = 120;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic [3:0] key = 4'b0001;
  always #5 clk = ~clk;

  vga_demo_if vga ();

  vga_demo_top #(.TICK_CYCLES(TICK), .BOX(BOX)) dut (
    .CLOCK_50 (clk),
    .KEY      (key),
    .vga      (vga)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- model ----------------
  int         n_pass = 0, n_total = 0;
  int         n_plot = 0, n_black = 0;
  logic [17:0] last_px = '0;
  logic [17:0] exp_q[$];

  int         m_x, m_y, m_dx, m_dy;
  logic [2:0] m_col;

  function automatic logic [17:0] pack(input int x, input int y, input logic [2:0] c);
    logic [7:0] xx;
    logic [6:0] yy;
    xx = 8'(x);
    yy = 7'(y);
    return {xx, yy, c};
  endfunction

  function automatic logic [2:0] col_after(input logic [2:0] c);
    return 3'((int'(c) % 7) + 1);
  endfunction

  task automatic push_rect(input int x, input int y, input int w, input int h, input logic [2:0] c);
    for (int r = 0; r < h; r++)
      for (int k = 0; k < w; k++)
        exp_q.push_back(pack(x + k, y + r, c));
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_dx = 1; m_dy = 1; m_col = 3'd7;
  endtask

  task automatic queue_step();
    int nx, ny;
`ifndef VGA_DEMO_TRAIL_EN
    push_rect(m_x, m_y, BOX, BOX, 3'd0);
`endif
    nx = m_x + m_dx;
    if (nx > SW - BOX || nx < 0) begin m_dx = -m_dx; nx = m_x + m_dx; end
    ny = m_y + m_dy;
    if (ny > SH - BOX || ny < 0) begin m_dy = -m_dy; ny = m_y + m_dy; end
    m_x = nx; m_y = ny;
    push_rect(m_x, m_y, BOX, BOX, m_col);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (vga.plot === 1'b1) begin
      logic [17:0] got, e;
      got = {vga.VGA_X, vga.VGA_Y, vga.VGA_COLOR};
      n_plot++;
      if (vga.VGA_COLOR == 3'd0) n_black++;
      last_px = got;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d, no pixel expected",
                 got[17:10], got[9:3], got[2:0]);
      end else begin
        e = exp_q.pop_front();
        if (got !== e)
          $display("FAIL pixel: got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                   got[17:10], got[9:3], got[2:0], e[17:10], e[9:3], e[2:0]);
        else n_pass++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_key1();
    key[1] = 1'b1;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    key[1] = 1'b0;
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    key = 4'b0001;
    cycles(4);
    n_total++; if (vga.plot !== 1'b0) $display("FAIL reset_plot: got %0b expected 0", vga.plot); else n_pass++;
    n_total++; if (vga.VGA_X !== 8'd0) $display("FAIL reset_x: got %0d expected 0", vga.VGA_X); else n_pass++;
    n_total++; if (vga.VGA_Y !== 7'd0) $display("FAIL reset_y: got %0d expected 0", vga.VGA_Y); else n_pass++;
    n_total++; if (vga.VGA_COLOR !== 3'd0) $display("FAIL reset_color: got %0d expected 0", vga.VGA_COLOR); else n_pass++;
  endtask

  task automatic test_clear();
    bit ok;
    int p0;
    model_reset();
    push_rect(0, 0, SW, SH, 3'd0);
    push_rect(m_x, m_y, BOX, BOX, m_col);
    p0 = n_plot;
    @(negedge clk); key[0] = 1'b0;
    wait_drain(SW * SH + BOX * BOX + 200, ok);
    n_total++; if (!ok) $display("FAIL clear_done: %0d pixels still pending", exp_q.size()); else n_pass++;
    n_total++; if (n_plot - p0 !== SW * SH + BOX * BOX)
      $display("FAIL clear_count: got %0d pulses expected %0d", n_plot - p0, SW * SH + BOX * BOX); else n_pass++;
    n_total++; if (last_px !== pack(7, 7, 3'd7))
      $display("FAIL first_box_last_px: got %h expected %h", last_px, pack(7, 7, 3'd7)); else n_pass++;
  endtask

  task automatic test_step();
    bit ok;
    int b0, exp_black;
    b0 = n_black;
`ifdef VGA_DEMO_TRAIL_EN
    exp_black = 0;
`else
    exp_black = BOX * BOX;
`endif
    queue_step();
    wait_drain(4 * TICK + 200, ok);
    n_total++; if (!ok) $display("FAIL step_done: %0d pixels pending", exp_q.size()); else n_pass++;
    n_total++; if (n_black - b0 !== exp_black)
      $display("FAIL step_black: got %0d black pulses expected %0d", n_black - b0, exp_black); else n_pass++;
    n_total++; if (last_px !== pack(8, 8, 3'd7))
      $display("FAIL step_last_px: got %h expected %h", last_px, pack(8, 8, 3'd7)); else n_pass++;
  endtask

  task automatic test_colour();
    bit ok;
    int n;
    // two presses held in WAIT: 7 -> 1 -> 2
    key[2] = 1'b1;
    pulse_key1(); pulse_key1();
    m_col = col_after(col_after(m_col));
    cycles(8);
    queue_step();
    key[2] = 1'b0;
    wait_drain(4 * TICK + 200, ok);
    n_total++; if (!ok) $display("FAIL colour_done: %0d pending", exp_q.size()); else n_pass++;
    n_total++; if (last_px[2:0] !== 3'd2)
      $display("FAIL colour_two_presses: got %0d expected 2", last_px[2:0]); else n_pass++;
    // random number of presses
    n = $urandom_range(1, 8);
    key[2] = 1'b1;
    for (int i = 0; i < n; i++) begin pulse_key1(); m_col = col_after(m_col); end
    cycles(8);
    queue_step();
    key[2] = 1'b0;
    wait_drain(4 * TICK + 200, ok);
    n_total++; if (!ok) $display("FAIL colour_rand_done: %0d pending", exp_q.size()); else n_pass++;
    n_total++; if (last_px[2:0] !== m_col || last_px[2:0] === 3'd0)
      $display("FAIL colour_random: got %0d expected %0d after %0d presses", last_px[2:0], m_col, n); else n_pass++;
  endtask

  task automatic test_pause();
    bit ok;
    int p0;
    key[2] = 1'b1;
    p0 = n_plot;
    for (int i = 0; i < 3 * TICK + 10; i++) begin
      @(negedge clk);
      key[3] = 1'($urandom_range(0, 1));
    end
    n_total++; if (n_plot - p0 !== 0)
      $display("FAIL pause_quiet: got %0d pulses expected 0", n_plot - p0); else n_pass++;
    queue_step();
    key[2] = 1'b0;
    wait_drain(4 * TICK + 200, ok);
    n_total++; if (!ok) $display("FAIL pause_resume: %0d pending", exp_q.size()); else n_pass++;
  endtask

  task automatic test_bounce();
    bit ok, seen_x, seen_y;
    int pre_x, pre_y;
    seen_x = 1'b0; seen_y = 1'b0;
    for (int s = 0; s < 200; s++) begin
      pre_x = m_x; pre_y = m_y;
      key[3] = 1'($urandom_range(0, 1));
      queue_step();
      wait_drain(4 * TICK + 200, ok);
      if (!ok) begin
        n_total++;
        $display("FAIL bounce_step: step %0d stalled with %0d pending", s, exp_q.size());
        break;
      end
      if (pre_x == SW - BOX) begin
        seen_x = 1'b1;
        n_total++; if (last_px[17:10] !== 8'd158)
          $display("FAIL bounce_x: got last x %0d expected 158", last_px[17:10]); else n_pass++;
      end
      if (pre_y == SH - BOX) begin
        seen_y = 1'b1;
        n_total++; if (last_px[9:3] !== 7'd118)
          $display("FAIL bounce_y: got last y %0d expected 118", last_px[9:3]); else n_pass++;
      end
      if (seen_x && seen_y) break;
    end
    n_total++; if (!(seen_x && seen_y))
      $display("FAIL bounce_reached: got x_seen=%0b y_seen=%0b expected 1 1", seen_x, seen_y); else n_pass++;
  endtask

  task automatic test_reset_mid_draw();
    bit ok, hit;
    int p0;
    queue_step();
    hit = 1'b0;
    for (int i = 0; i < 4 * TICK + 200; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() > 0 && exp_q.size() <= BOX * BOX / 2) begin hit = 1'b1; break; end
    end
    n_total++; if (!hit) $display("FAIL mid_draw_reached: got %0d pending expected 1..%0d", exp_q.size(), BOX * BOX / 2); else n_pass++;
    key[0] = 1'b1;
    #2 exp_q.delete();
    @(negedge clk); #1;
    n_total++; if (vga.plot !== 1'b0) $display("FAIL mid_reset_plot: got %0b expected 0", vga.plot); else n_pass++;
    n_total++; if (vga.VGA_X !== 8'd0 || vga.VGA_Y !== 7'd0)
      $display("FAIL mid_reset_xy: got %0d,%0d expected 0,0", vga.VGA_X, vga.VGA_Y); else n_pass++;
    cycles(2);
    model_reset();
    for (int i = 0; i < 8; i++) m_col = col_after(m_col);
    push_rect(0, 0, SW, SH, 3'd0);
    push_rect(0, 0, BOX, BOX, m_col);
    p0 = n_plot;
    key[0] = 1'b0;
    for (int i = 0; i < 8; i++) pulse_key1();
    wait_drain(SW * SH + BOX * BOX + 200, ok);
    n_total++; if (!ok) $display("FAIL restart_done: %0d pending", exp_q.size()); else n_pass++;
    n_total++; if (n_plot - p0 !== SW * SH + BOX * BOX)
      $display("FAIL restart_count: got %0d expected %0d", n_plot - p0, SW * SH + BOX * BOX); else n_pass++;
    n_total++; if (last_px !== pack(7, 7, 3'd1))
      $display("FAIL eight_presses_colour: got %h expected %h", last_px, pack(7, 7, 3'd1)); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_clear();
    test_step();
    test_colour();
    test_pause();
    test_bounce();
    test_reset_mid_draw();
    cycles(4);
    n_total++; if (exp_q.size() !== 0)
      $display("FAIL final_queue: got %0d pending expected 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
